bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum cycles a granted transfer waits for mem_ready_in before abort (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port instr_address_in, input, 64: fetch-side address.
REQ-005 SHALL have port instr_read_in, input, 1: fetch read request, held until instr_ready_out.
REQ-006 SHALL have port instr_read_value_out, output, 64: fetch read data.
REQ-007 SHALL have port instr_ready_out, output, 1: fetch transfer complete.
REQ-008 SHALL have port data_address_in, input, 64: load/store address.
REQ-009 SHALL have ports data_read_in and data_write_in, input, 1 each: load/store request, held until data_ready_out; never both high.
REQ-010 SHALL have port data_write_mask_in, input, 8: byte enables, bit i = byte i.
REQ-011 SHALL have port data_write_value_in, input, 64: store data.
REQ-012 SHALL have port data_read_value_out, output, 64: load data.
REQ-013 SHALL have port data_ready_out, output, 1: load/store complete.
REQ-014 SHALL have ports mem_address_out (64), mem_read_out (1), mem_write_out (1), mem_write_mask_out (8), mem_write_value_out (64), all outputs: shared memory bus request.
REQ-015 SHALL have ports mem_read_value_in (64) and mem_ready_in (1), inputs: memory response.
REQ-016 SHALL have port bus_error_out, output, 1: one-cycle pulse on timeout abort.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT_INSTR, GRANT_DATA.
REQ-018 In IDLE, SHALL drive all mem_* strobes and both ready outputs low; bus address/value outputs 0.
REQ-019 In IDLE with exactly one requester active, SHALL move to that requester's GRANT state next cycle.
REQ-020 In IDLE with both active, SHALL grant data unless last completed grant was data, then instr (alternating; no starvation).
REQ-021 In GRANT_x, SHALL drive mem_* outputs combinationally from requester x's current inputs; instr grant forces mem_write_out=0, mask=0.
REQ-022 In GRANT_x, SHALL pass mem_ready_in combinationally to x's ready output; non-granted ready SHALL be 0.
REQ-023 SHALL route mem_read_value_in to granted requester's read value output; non-granted read value SHALL be 0.
REQ-024 On mem_ready_in high in GRANT_x, SHALL return to IDLE next cycle and record x as last grant; minimum request-to-ready latency is 1 cycle (arbitration) plus memory latency.
REQ-025 SHALL not re-arbitrate back-to-back: one IDLE cycle always separates grants.
REQ-026 SHALL keep a 16-bit wait counter, cleared on entering GRANT_x, incremented each GRANT cycle without mem_ready_in.
REQ-027 When counter equals TIMEOUT_CYCLES-1 and mem_ready_in low, SHALL in that cycle deassert mem strobes, assert x's ready with read value all-ones, pulse bus_error_out, and return to IDLE.
REQ-028 mem_ready_in in IDLE SHALL be ignored.
REQ-029 Requester dropping its request while granted is illegal; arbiter SHALL hold grant until ready or timeout.

Reset
REQ-030 On reset assertion, SHALL immediately enter IDLE, clear counter, set last grant to instr, and drive all outputs 0, including mid-transfer.
REQ-031 After reset release, SHALL arbitrate on the first rising edge.

Structure
REQ-032 SHALL place FSM state enum and bus width constants (address 64, data 64, mask 8) in shared package bus_pkg.
REQ-033 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-034 Instr-only read 0x1000, memory ready after 3 cycles with 0xDEADBEEF -> instr_ready_out high on cycle 4 with value 0xDEADBEEF; data_ready_out stays 0.
REQ-035 Simultaneous instr read 0x2000 and data write 0x3000 mask 0x0F, fresh reset -> data granted first, mem_write_out=1, mask 0x0F; instr granted after one IDLE cycle.
REQ-036 Both requesters continuously active for 6 transfers -> grants alternate data, instr, data, instr, data, instr.
REQ-037 Data read, mem_ready_in never asserted, TIMEOUT_CYCLES=4 -> data_ready_out and bus_error_out high on 4th grant cycle, read value 0xFFFFFFFFFFFFFFFF, FSM IDLE next cycle.
REQ-038 Reset asserted mid GRANT_DATA -> all outputs 0 same cycle; after release, pending instr request granted on first edge.

Source files
------------

// File: rtl/bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the two-master memory bus arbiter.
//                Holds the bus width constants and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Shared memory bus widths
  localparam int c_ADDR_W = 64;
  localparam int c_DATA_W = 64;
  localparam int c_MASK_W = 8;

  // Width of the transfer wait counter
  localparam int c_CNT_W  = 16;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GRANT_INSTR = 2'd1,
    ST_GRANT_DATA  = 2'd2
  } arb_state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Arbitrates one shared memory bus between an instruction-fetch
//                master and a load/store master. Grants alternate when both
//                masters request, so neither can be starved. A granted
//                transfer that sees no mem_ready_in for TIMEOUT_CYCLES cycles
//                is aborted: the master gets ready with an all-ones read value
//                and bus_error_out pulses for one cycle.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk                  in   1   clock, all state updates on rising edge
//    reset                in   1   asynchronous active-high reset
//    instr_address_in     in  64   fetch address
//    instr_read_in        in   1   fetch read request (held until ready)
//    instr_read_value_out out 64   fetch read data
//    instr_ready_out      out  1   fetch transfer complete
//    data_address_in      in  64   load/store address
//    data_read_in         in   1   load request (held until ready)
//    data_write_in        in   1   store request (held until ready)
//    data_write_mask_in   in   8   store byte enables, bit i = byte i
//    data_write_value_in  in  64   store data
//    data_read_value_out  out 64   load data
//    data_ready_out       out  1   load/store complete
//    mem_address_out      out 64   bus address
//    mem_read_out         out  1   bus read strobe
//    mem_write_out        out  1   bus write strobe
//    mem_write_mask_out   out  8   bus byte enables
//    mem_write_value_out  out 64   bus write data
//    mem_read_value_in    in  64   bus read data
//    mem_ready_in         in   1   bus transfer complete
//    bus_error_out        out  1   one-cycle pulse on timeout abort
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [c_ADDR_W-1:0] instr_address_in,
  input  logic                instr_read_in,
  output logic [c_DATA_W-1:0] instr_read_value_out,
  output logic                instr_ready_out,

  input  logic [c_ADDR_W-1:0] data_address_in,
  input  logic                data_read_in,
  input  logic                data_write_in,
  input  logic [c_MASK_W-1:0] data_write_mask_in,
  input  logic [c_DATA_W-1:0] data_write_value_in,
  output logic [c_DATA_W-1:0] data_read_value_out,
  output logic                data_ready_out,

  output logic [c_ADDR_W-1:0] mem_address_out,
  output logic                mem_read_out,
  output logic                mem_write_out,
  output logic [c_MASK_W-1:0] mem_write_mask_out,
  output logic [c_DATA_W-1:0] mem_write_value_out,
  input  logic [c_DATA_W-1:0] mem_read_value_in,
  input  logic                mem_ready_in,

  output logic                bus_error_out
);

  // Counter value on the last grant cycle before abort
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_DATA_W-1:0] c_ALL_ONES = '1;

  arb_state_t         r_state;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_last_data;   // last completed grant went to data

  logic w_instr_req;
  logic w_data_req;
  logic w_granted;
  logic w_timeout;

  assign w_instr_req = instr_read_in;
  assign w_data_req  = data_read_in | data_write_in;
  assign w_granted   = (r_state == ST_GRANT_INSTR) || (r_state == ST_GRANT_DATA);

  // Abort fires only when memory is also silent in the final allowed cycle;
  // a late mem_ready_in on that same cycle still completes normally.
  assign w_timeout   = w_granted && (r_wait_cnt == c_TO_LAST) && !mem_ready_in;

  // --------------------------------------------------------------------------
  // State, wait counter and fairness flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_last_data <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Counter is cleared here so every grant starts counting from zero
          r_wait_cnt <= '0;
          if (w_data_req && (!w_instr_req || !r_last_data)) begin
            r_state <= ST_GRANT_DATA;
          end else if (w_instr_req) begin
            r_state <= ST_GRANT_INSTR;
          end
        end

        ST_GRANT_INSTR, ST_GRANT_DATA: begin
          // Grant is held until completion or abort, regardless of whether
          // the requester still drives its request.
          if (mem_ready_in || w_timeout) begin
            r_state     <= ST_IDLE;
            r_last_data <= (r_state == ST_GRANT_DATA);
          end else begin
            r_wait_cnt  <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus and requester outputs
  // Routed combinationally from the granted master; reset forces every
  // output low in the same cycle it is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    instr_read_value_out = '0;
    instr_ready_out      = 1'b0;
    data_read_value_out  = '0;
    data_ready_out       = 1'b0;
    mem_address_out      = '0;
    mem_read_out         = 1'b0;
    mem_write_out        = 1'b0;
    mem_write_mask_out   = '0;
    mem_write_value_out  = '0;
    bus_error_out        = 1'b0;

    if (!reset) begin
      case (r_state)
        ST_GRANT_INSTR: begin
          mem_address_out      = instr_address_in;
          mem_read_out         = instr_read_in & ~w_timeout;
          instr_ready_out      = mem_ready_in | w_timeout;
          instr_read_value_out = w_timeout ? c_ALL_ONES : mem_read_value_in;
          bus_error_out        = w_timeout;
        end

        ST_GRANT_DATA: begin
          mem_address_out      = data_address_in;
          mem_read_out         = data_read_in  & ~w_timeout;
          mem_write_out        = data_write_in & ~w_timeout;
          mem_write_mask_out   = data_write_mask_in;
          mem_write_value_out  = data_write_value_in;
          data_ready_out       = mem_ready_in | w_timeout;
          data_read_value_out  = w_timeout ? c_ALL_ONES : mem_read_value_in;
          bus_error_out        = w_timeout;
        end

        default: begin
        end
      endcase
    end
  end

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter with a short
//                timeout (TIMEOUT_CYCLES = 4). Inputs change 1 ns after the
//                rising edge and outputs are sampled 1 ns later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] instr_address_in;
  logic        instr_read_in;
  logic [63:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [63:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [7:0]  data_write_mask_in;
  logic [63:0] data_write_value_in;
  logic [63:0] data_read_value_out;
  logic        data_ready_out;
  logic [63:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [7:0]  mem_write_mask_out;
  logic [63:0] mem_write_value_out;
  logic [63:0] mem_read_value_in;
  logic        mem_ready_in;
  logic        bus_error_out;

  int n_chk = 0;
  int n_err = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in),
    .bus_error_out        (bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every output low: IDLE or reset
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {51'd0, instr_ready_out, data_ready_out, mem_read_out,
                        mem_write_out, bus_error_out, mem_write_mask_out}, 64'd0);
    chk({tag, "_adr"}, mem_address_out, 64'd0);
    chk({tag, "_wv"},  mem_write_value_out, 64'd0);
    chk({tag, "_irv"}, instr_read_value_out, 64'd0);
    chk({tag, "_drv"}, data_read_value_out, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b1;
    instr_address_in    = '0;
    instr_read_in       = 1'b0;
    data_address_in     = '0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    mem_read_value_in   = '0;
    mem_ready_in        = 1'b0;

    // ---- reset state -------------------------------------------------------
    step(); step();
    #1 chk_zero("rst");
    step();
    reset = 1'b0;
    #1 chk_zero("post_rst");

    // ---- instr-only read, ready on 4th cycle after request -----------------
    step();                               // cycle 0: request, IDLE
    instr_address_in  = 64'h1000;
    instr_read_in     = 1'b1;
    mem_ready_in      = 1'b1;             // stray ready in IDLE is ignored
    mem_read_value_in = 64'h0BAD;
    #1 chk("a_idle_ign_rdy", {63'd0, instr_ready_out}, 64'd0);
    chk("a_idle_rd", {63'd0, mem_read_out}, 64'd0);
    mem_ready_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin    // cycles 1..3: granted, memory busy
      step();
      #1 chk("a_adr", mem_address_out, 64'h1000);
      chk("a_rd_wr", {62'd0, mem_read_out, mem_write_out}, 64'd2);
      chk("a_rdy", {62'd0, instr_ready_out, data_ready_out}, 64'd0);
    end
    step();                               // cycle 4: memory ready
    mem_ready_in      = 1'b1;
    mem_read_value_in = 64'hDEADBEEF;
    #1 chk("a_irdy", {63'd0, instr_ready_out}, 64'd1);
    chk("a_ival", instr_read_value_out, 64'hDEADBEEF);
    chk("a_drdy_err", {62'd0, data_ready_out, bus_error_out}, 64'd0);
    chk("a_dval", data_read_value_out, 64'd0);
    step();
    instr_read_in = 1'b0;
    mem_ready_in  = 1'b0;
    #1 chk_zero("a_back_idle");

    // ---- fresh reset, simultaneous instr read and data write ---------------
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    instr_address_in    = 64'h2000;
    instr_read_in       = 1'b1;
    data_address_in     = 64'h3000;
    data_write_in       = 1'b1;
    data_write_mask_in  = 8'h0F;
    data_write_value_in = 64'h1122334455667788;
    #1 chk_zero("b_idle");
    step();                               // data wins
    #1 chk("b_adr", mem_address_out, 64'h3000);
    chk("b_rd_wr", {62'd0, mem_read_out, mem_write_out}, 64'd1);
    chk("b_mask", {56'd0, mem_write_mask_out}, 64'h0F);
    chk("b_wv", mem_write_value_out, 64'h1122334455667788);
    mem_ready_in = 1'b1;
    #1 chk("b_rdy", {62'd0, instr_ready_out, data_ready_out}, 64'd1);
    step();                               // separating IDLE cycle
    data_write_in = 1'b0;
    mem_ready_in  = 1'b0;
    #1 chk_zero("b_gap");
    step();                               // instr granted
    #1 chk("b_i_adr", mem_address_out, 64'h2000);
    chk("b_i_rd_wr_mask", {53'd0, mem_read_out, mem_write_out, 1'b0, mem_write_mask_out}, 64'h400);
    mem_ready_in      = 1'b1;
    mem_read_value_in = 64'h55;
    #1 chk("b_i_val", instr_read_value_out, 64'h55);
    chk("b_i_dval_rdy", {data_read_value_out[62:0], data_ready_out}, 64'd0);
    step();
    instr_read_in = 1'b0;
    mem_ready_in  = 1'b0;

    // ---- both continuously active: alternate data/instr -------------------
    instr_address_in = 64'h4000;
    data_address_in  = 64'h5000;
    instr_read_in    = 1'b1;
    data_read_in     = 1'b1;
    for (int g = 0; g < 6; g++) begin
      #1 chk("c_gap_rd", {63'd0, mem_read_out}, 64'd0);
      step();
      #1 chk("c_adr", mem_address_out, (g % 2 == 0) ? 64'h5000 : 64'h4000);
      mem_ready_in = 1'b1;
      #1 chk("c_rdy", {62'd0, instr_ready_out, data_ready_out},
             (g % 2 == 0) ? 64'd1 : 64'd2);
      step();
      mem_ready_in = 1'b0;
    end
    instr_read_in = 1'b0;
    data_read_in  = 1'b0;

    // ---- data read that times out after 4 grant cycles ---------------------
    step();
    data_address_in   = 64'h6000;
    data_read_in      = 1'b1;
    mem_read_value_in = 64'h1234;
    step();
    for (int c = 1; c <= 3; c++) begin
      #1 chk("d_wait", {61'd0, mem_read_out, data_ready_out, bus_error_out}, 64'd4);
      step();
    end
    #1 chk("d_to", {61'd0, mem_read_out, data_ready_out, bus_error_out}, 64'd3);
    chk("d_to_val", data_read_value_out, 64'hFFFFFFFFFFFFFFFF);
    step();
    data_read_in = 1'b0;
    #1 chk_zero("d_idle");

    // ---- reset in the middle of a data grant -------------------------------
    step();
    data_address_in  = 64'h7000;
    data_read_in     = 1'b1;
    step();
    instr_address_in = 64'h8000;
    instr_read_in    = 1'b1;
    #1 chk("e_adr", mem_address_out, 64'h7000);
    reset        = 1'b1;
    data_read_in = 1'b0;
    #1 chk_zero("e_rst");
    step();
    reset = 1'b0;
    #1 chk_zero("e_rel");
    step();
    #1 chk("e_i_adr", mem_address_out, 64'h8000);
    chk("e_i_rd", {63'd0, mem_read_out}, 64'd1);
    mem_ready_in = 1'b1;
    #1 chk("e_i_rdy", {63'd0, instr_ready_out}, 64'd1);
    step();
    instr_read_in = 1'b0;
    mem_ready_in  = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
